// File: rtl/mesi_isc_cpu_agent.sv
// mesi_isc_cpu_agent
//   Per-CPU coherence agent sitting between one CPU and the MESI coherence
//   controller. CPU loads/stores that miss (or a store to a shared line) become
//   MBUS broadcast requests. The agent holds each request until it is acked,
//   then waits for the matching CBUS enable. CBUS snoops and enables are
//   serviced in any state with a single-cycle ack. A small direct-mapped table
//   holds the MESI state of each line.
//
// Ports
//   clk, rst                   clock, synchronous active-high reset
//   cpu_req_i/cpu_wr_i/        CPU request valid, store flag and address
//     cpu_addr_i
//   cpu_ready_o                request accepted when cpu_req_i && cpu_ready_o
//   cpu_done_o                 1-cycle completion pulse
//   mbus_cmd_o/mbus_addr_o     broadcast request to the controller,
//                              held until mbus_ack_i
//   mbus_ack_i                 request ack from the controller
//   cbus_cmd_i/cbus_addr_i     snoop/enable command from the controller
//   cbus_ack_o                 1-cycle ack per CBUS command
//   wb_o                       1-cycle pulse: modified data written back
module mesi_isc_cpu_agent #(
    parameter int ADDR_WIDTH     = 32,
    parameter int CBUS_CMD_WIDTH = 3,
    parameter int MBUS_CMD_WIDTH = 3,
    parameter int LINES          = 4,
    parameter int LINES_LOG2     = 2,
    parameter int OFFSET_BITS    = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cpu_req_i,
    input  logic                      cpu_wr_i,
    input  logic [ADDR_WIDTH-1:0]     cpu_addr_i,
    output logic                      cpu_ready_o,
    output logic                      cpu_done_o,
    output logic [MBUS_CMD_WIDTH-1:0] mbus_cmd_o,
    output logic [ADDR_WIDTH-1:0]     mbus_addr_o,
    input  logic                      mbus_ack_i,
    input  logic [CBUS_CMD_WIDTH-1:0] cbus_cmd_i,
    input  logic [ADDR_WIDTH-1:0]     cbus_addr_i,
    output logic                      cbus_ack_o,
    output logic                      wb_o
);
    localparam int TAG_W = ADDR_WIDTH - OFFSET_BITS;

    localparam logic [MBUS_CMD_WIDTH-1:0] MBUS_NOP      = MBUS_CMD_WIDTH'(0);
    localparam logic [MBUS_CMD_WIDTH-1:0] MBUS_WR_BROAD = MBUS_CMD_WIDTH'(3);
    localparam logic [MBUS_CMD_WIDTH-1:0] MBUS_RD_BROAD = MBUS_CMD_WIDTH'(4);

    localparam logic [CBUS_CMD_WIDTH-1:0] CBUS_NOP      = CBUS_CMD_WIDTH'(0);
    localparam logic [CBUS_CMD_WIDTH-1:0] CBUS_WR_SNOOP = CBUS_CMD_WIDTH'(1);
    localparam logic [CBUS_CMD_WIDTH-1:0] CBUS_RD_SNOOP = CBUS_CMD_WIDTH'(2);
    localparam logic [CBUS_CMD_WIDTH-1:0] CBUS_EN_WR    = CBUS_CMD_WIDTH'(3);
    localparam logic [CBUS_CMD_WIDTH-1:0] CBUS_EN_RD    = CBUS_CMD_WIDTH'(4);

    localparam logic [1:0] ST_I = 2'd0;
    localparam logic [1:0] ST_S = 2'd1;
    localparam logic [1:0] ST_E = 2'd2;
    localparam logic [1:0] ST_M = 2'd3;

    typedef enum logic [1:0] {IDLE, REQ, WAIT_EN} state_t;

    state_t                    state_q, state_d;
    logic [TAG_W-1:0]          req_line_q;
    logic                      req_wr_q;
    logic [MBUS_CMD_WIDTH-1:0] mbus_cmd_q;
    logic [ADDR_WIDTH-1:0]     mbus_addr_q;
    logic                      done_q, ack_q, wb_q;
    logic                      cb_busy_q;   // CBUS command acked, waiting for NOP

    logic [TAG_W-1:0]          tag_q [LINES];
    logic [1:0]                st_q  [LINES];

    // Lookup views
    logic [TAG_W-1:0]      cb_line, cpu_line;
    logic [LINES_LOG2-1:0] cb_idx, cpu_idx, req_idx;
    logic [1:0]            cb_st, cpu_st, req_st;
    logic                  cb_hit, cpu_hit, cb_take, cpu_acc;
    logic                  miss_path, hit_done, set_m, en_fill;

    // Low offset bits of the snoop address never select anything.
    logic unused_cbus_off;
    assign unused_cbus_off = ^cbus_addr_i[OFFSET_BITS-1:0];

    assign cb_line  = cbus_addr_i[ADDR_WIDTH-1:OFFSET_BITS];
    assign cpu_line = cpu_addr_i[ADDR_WIDTH-1:OFFSET_BITS];
    assign cb_idx   = cb_line[LINES_LOG2-1:0];
    assign cpu_idx  = cpu_line[LINES_LOG2-1:0];
    assign req_idx  = req_line_q[LINES_LOG2-1:0];
    assign cb_st    = st_q[cb_idx];
    assign cpu_st   = st_q[cpu_idx];
    assign req_st   = st_q[req_idx];
    assign cb_hit   = (tag_q[cb_idx] == cb_line) && (cb_st != ST_I);
    assign cpu_hit  = (tag_q[cpu_idx] == cpu_line) && (cpu_st != ST_I);

    // A new CBUS command is taken only once the previous one dropped to NOP.
    assign cb_take = !cb_busy_q && (cbus_cmd_i != CBUS_NOP);

    // Any CBUS service blocks the CPU for that cycle, so the table sees at
    // most one writer per cycle.
    assign cpu_ready_o = !rst && (state_q == IDLE) && !cb_take;
    assign cpu_acc     = cpu_req_i && cpu_ready_o;

    assign cpu_done_o  = done_q;
    assign cbus_ack_o  = ack_q;
    assign wb_o        = wb_q;
    assign mbus_cmd_o  = mbus_cmd_q;
    assign mbus_addr_o = mbus_addr_q;

    always_comb begin
        state_d   = state_q;
        miss_path = 1'b0;
        hit_done  = 1'b0;
        set_m     = 1'b0;
        en_fill   = 1'b0;
        case (state_q)
            IDLE: begin
                if (cpu_acc) begin
                    // Load hits any valid state; store needs E or M locally.
                    miss_path = !(cpu_hit && (!cpu_wr_i || cpu_st == ST_E || cpu_st == ST_M));
                    hit_done  = !miss_path;
                    set_m     = cpu_wr_i && cpu_hit && (cpu_st == ST_E);
                    if (miss_path)
                        state_d = REQ;
                end
            end
            REQ: begin
                if (mbus_ack_i)
                    state_d = WAIT_EN;
            end
            WAIT_EN: begin
                en_fill = cb_take && (cb_line == req_line_q) &&
                          ((req_wr_q && cbus_cmd_i == CBUS_EN_WR) ||
                           (!req_wr_q && cbus_cmd_i == CBUS_EN_RD));
                if (en_fill)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            req_line_q  <= '0;
            req_wr_q    <= 1'b0;
            mbus_cmd_q  <= MBUS_NOP;
            mbus_addr_q <= '0;
            done_q      <= 1'b0;
            ack_q       <= 1'b0;
            wb_q        <= 1'b0;
            cb_busy_q   <= 1'b0;
            for (int i = 0; i < LINES; i++) begin
                tag_q[i] <= '0;
                st_q[i]  <= ST_I;
            end
        end else begin
            state_q <= state_d;
            done_q  <= hit_done || en_fill;
            ack_q   <= cb_take;
            wb_q    <= 1'b0;

            if (cb_take)
                cb_busy_q <= 1'b1;
            else if (cbus_cmd_i == CBUS_NOP)
                cb_busy_q <= 1'b0;

            if (cpu_acc && miss_path) begin
                req_line_q  <= cpu_line;
                req_wr_q    <= cpu_wr_i;
                mbus_cmd_q  <= cpu_wr_i ? MBUS_WR_BROAD : MBUS_RD_BROAD;
                mbus_addr_q <= cpu_addr_i;
            end else if (state_q == REQ && mbus_ack_i) begin
                mbus_cmd_q <= MBUS_NOP;
            end

            if (set_m)
                st_q[cpu_idx] <= ST_M;

            if (en_fill) begin
                // Fill replaces whatever sits at the index; a modified victim
                // of a different line is written back.
                tag_q[req_idx] <= req_line_q;
                st_q[req_idx]  <= req_wr_q ? ST_M : ST_S;
                wb_q           <= (req_st == ST_M) && (tag_q[req_idx] != req_line_q);
            end else if (cb_take && cb_hit) begin
                if (cbus_cmd_i == CBUS_WR_SNOOP) begin
                    st_q[cb_idx] <= ST_I;
                    wb_q         <= (cb_st == ST_M);
                end else if (cbus_cmd_i == CBUS_RD_SNOOP &&
                             (cb_st == ST_M || cb_st == ST_E)) begin
                    st_q[cb_idx] <= ST_S;
                    wb_q         <= (cb_st == ST_M);
                end
            end
        end
    end
endmodule
